// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Arbitrates among `drvrs` drivers, each presenting a pending FIFO head, and
//   moves one packet per grant onto a shared bus. The destination ID lives in
//   the top byte of the packet. A unicast destination below `drvrs` pushes to
//   that driver, and the `broadcast` ID pushes to every driver except the
//   source. Any other ID drops the packet.
//   Transfer sequence: IDLE (arbitrate) -> POP (consume head) -> PUSH (deliver).
//   That gives one packet every three cycles under continuous demand.
//
// Optional feature macro: BUS_ID_CHECK_EN
//   When it is defined, an invalid destination pulses `err` during the PUSH
//   cycle. When it is not defined, `err` is tied to 0. In both builds the
//   packet is dropped.
//
// Parameters
//   drvrs     number of drivers (2..64)
//   pckg_sz   packet width in bits (>= 16)
//   broadcast destination ID that addresses all other drivers
//   arb_mode  0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports
//   clk       bus clock, rising edge
//   reset     asynchronous, active-high reset
//   pndng     bit i: driver i has a packet at its FIFO head
//   D_pop     slice i: head packet of driver i
//   pop       one-hot pulse during POP that consumes the winner's head
//   push      pulse during PUSH, one bit per receiving driver
//   D_push    packet replicated on every slice; holds its value outside PUSH
//   busy      high while a transfer is in flight (POP or PUSH)
//   grant_id  index of the current or most recent winner
//   err       one-cycle invalid-destination pulse (BUS_ID_CHECK_EN only)
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int         drvrs     = 16,
    parameter int         pckg_sz   = 32,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         arb_mode  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push,
    output logic                       busy,
    output logic [7:0]                 grant_id,
    output logic                       err
);

    localparam int IDX_W = $clog2(drvrs);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [drvrs-1:0]           pop_q, pop_d;
    logic [drvrs-1:0]           push_q, push_d;
    logic [drvrs*pckg_sz-1:0]   dpush_q, dpush_d;
    logic                       busy_q, busy_d;
    logic [7:0]                 grant_q, grant_d;
    logic                       err_q, err_d;

    logic [drvrs-1:0]           upper_s;
    logic [IDX_W-1:0]           win_s;
    logic [drvrs-1:0]           win_oh_s;
    logic [drvrs-1:0]           src_oh_s;
    logic [pckg_sz-1:0]         head_s;
    logic [7:0]                 dest_s;
    logic [drvrs-1:0]           uni_oh_s;
    logic                       is_bcast_s;
    logic [drvrs-1:0]           route_s;

    // Returns the lowest set bit index of v (0 when v is empty).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [drvrs-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = drvrs - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Winner selection, head-packet mux and destination decode.
    always_comb begin
        // Round-robin search from ptr with wrap. First look at requesters at
        // or above ptr. If there are none, the lowest requester overall wins.
        for (int i = 0; i < drvrs; i++) begin
            upper_s[i] = pndng[i] && (IDX_W'(i) >= ptr_q);
        end
        if (arb_mode == 0) begin
            if (|upper_s) begin
                win_s = lowest_idx(upper_s);
            end else begin
                win_s = lowest_idx(pndng);
            end
        end else begin
            win_s = lowest_idx(pndng);
        end
        for (int i = 0; i < drvrs; i++) begin
            win_oh_s[i] = (win_s == IDX_W'(i));
        end

        // The registered grant selects the head that is captured in POP.
        head_s = '0;
        for (int i = 0; i < drvrs; i++) begin
            src_oh_s[i] = (grant_q == 8'(i));
            head_s      = head_s | ({pckg_sz{src_oh_s[i]}} & D_pop[i*pckg_sz +: pckg_sz]);
        end
        dest_s = head_s[pckg_sz-1 -: 8];

        // If dest < drvrs, exactly one bit of uni_oh_s is set; otherwise none.
        for (int i = 0; i < drvrs; i++) begin
            uni_oh_s[i] = (dest_s == 8'(i));
        end
        is_bcast_s = (dest_s == broadcast);
        if (|uni_oh_s) begin
            route_s = uni_oh_s;
        end else if (is_bcast_s) begin
            route_s = ~src_oh_s;
        end else begin
            route_s = '0;
        end
    end

    // Next-state and next-output logic of the IDLE/POP/PUSH sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pop_d   = '0;
        push_d  = '0;
        dpush_d = dpush_q;
        busy_d  = busy_q;
        grant_d = grant_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pndng) begin
                    state_d = S_POP;
                    busy_d  = 1'b1;
                    grant_d = 8'(win_s);
                    pop_d   = win_oh_s;
                    if (arb_mode == 0) begin
                        ptr_d = (win_s == IDX_W'(drvrs - 1)) ? '0 : win_s + IDX_W'(1);
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                // Head is captured here. pndng is deliberately not re-checked.
                state_d = S_PUSH;
                dpush_d = {drvrs{head_s}};
                push_d  = route_s;
`ifdef BUS_ID_CHECK_EN
                err_d   = ~(|uni_oh_s) & ~is_bcast_s;
`else
                err_d   = 1'b0;
`endif
            end
            S_PUSH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            dpush_q <= '0;
            busy_q  <= 1'b0;
            grant_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr with 4 drivers and 32-bit packets. A round-robin
// instance and a fixed-priority instance share the same stimulus. A
// transaction-level model predicts both every cycle, and directed literal
// checks pin the expected behaviour of the scenarios.
module tb_bus_arbiter_rr;

    localparam int N = 4;
    localparam int W = 32;

`ifdef BUS_ID_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [N-1:0]     pndng;
    logic [N*W-1:0]   D_pop;

    logic [N-1:0]     pop_rr, push_rr, pop_fp, push_fp;
    logic [N*W-1:0]   dpush_rr, dpush_fp;
    logic             busy_rr, busy_fp, err_rr, err_fp;
    logic [7:0]       gid_rr, gid_fp;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter_rr #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF), .arb_mode(0)) u_rr (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop_rr), .push(push_rr), .D_push(dpush_rr),
        .busy(busy_rr), .grant_id(gid_rr), .err(err_rr)
    );

    bus_arbiter_rr #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF), .arb_mode(1)) u_fp (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop_fp), .push(push_fp), .D_push(dpush_fp),
        .busy(busy_fp), .grant_id(gid_fp), .err(err_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Index 0 models the round-robin instance and index 1 the fixed-priority
    // instance. m_age counts cycles since the grant: 0 = no transfer, 1 = pop
    // cycle, 2 = push cycle.
    int             m_ptr [2];
    int             m_age [2];
    int             m_win [2];
    logic [N-1:0]   e_pop [2];
    logic [N-1:0]   e_push[2];
    logic [N*W-1:0] e_dpush[2];
    logic           e_busy[2];
    logic [7:0]     e_gid [2];
    logic           e_err [2];

    function automatic int pick(input int m, input logic [N-1:0] p, input int ptr);
        int r;
        bit found;
        r = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m == 0) ? (ptr + k) % N : k;
            if (!found && p[j]) begin
                r = j;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] head(input int w);
        return D_pop[w*W +: W];
    endfunction

    function automatic logic [N-1:0] route(input logic [W-1:0] pkt, input int src);
        logic [7:0] d;
        logic [N-1:0] all1;
        logic [N-1:0] one;
        d = pkt[W-1 -: 8];
        all1 = '1;
        one = 4'b0001;
        if (d < 8'(N)) return one << d;
        else if (d == 8'hFF) return all1 & ~(one << src);
        else return '0;
    endfunction

    function automatic logic bad_dest(input logic [W-1:0] pkt);
        logic [7:0] d;
        d = pkt[W-1 -: 8];
        return EXP_ERR & (d >= 8'(N)) & (d != 8'hFF);
    endfunction

    // Model update on every clock edge and on asynchronous reset.
    always @(posedge clk or posedge reset) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_ptr[m] <= 0; m_age[m] <= 0; m_win[m] <= 0;
                e_pop[m] <= '0; e_push[m] <= '0; e_dpush[m] <= '0;
                e_busy[m] <= 1'b0; e_gid[m] <= 8'd0; e_err[m] <= 1'b0;
            end else begin
                case (m_age[m])
                    0: begin
                        if (pndng != '0) begin
                            m_win[m]  <= pick(m, pndng, m_ptr[m]);
                            e_gid[m]  <= 8'(pick(m, pndng, m_ptr[m]));
                            e_pop[m]  <= 4'b0001 << pick(m, pndng, m_ptr[m]);
                            e_busy[m] <= 1'b1;
                            m_age[m]  <= 1;
                            if (m == 0) m_ptr[m] <= (pick(m, pndng, m_ptr[m]) + 1) % N;
                        end
                    end
                    1: begin
                        e_pop[m]   <= '0;
                        e_dpush[m] <= {N{head(m_win[m])}};
                        e_push[m]  <= route(head(m_win[m]), m_win[m]);
                        e_err[m]   <= bad_dest(head(m_win[m]));
                        m_age[m]   <= 2;
                    end
                    default: begin
                        e_push[m] <= '0;
                        e_err[m]  <= 1'b0;
                        e_busy[m] <= 1'b0;
                        m_age[m]  <= 0;
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("rr.pop",   128'(pop_rr),   128'(e_pop[0]));
        chk("rr.push",  128'(push_rr),  128'(e_push[0]));
        chk("rr.dpush", 128'(dpush_rr), 128'(e_dpush[0]));
        chk("rr.busy",  128'(busy_rr),  128'(e_busy[0]));
        chk("rr.gid",   128'(gid_rr),   128'(e_gid[0]));
        chk("rr.err",   128'(err_rr),   128'(e_err[0]));
        chk("fp.pop",   128'(pop_fp),   128'(e_pop[1]));
        chk("fp.push",  128'(push_fp),  128'(e_push[1]));
        chk("fp.dpush", 128'(dpush_fp), 128'(e_dpush[1]));
        chk("fp.busy",  128'(busy_fp),  128'(e_busy[1]));
        chk("fp.gid",   128'(gid_fp),   128'(e_gid[1]));
        chk("fp.err",   128'(err_fp),   128'(e_err[1]));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_pkt(input int d, input logic [7:0] dest, input logic [15:0] pl);
        D_pop[d*W +: W] = {dest, 8'h00, pl};
    endtask

    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        cyc(2);
        chk("reset.pop",   128'(pop_rr),   128'd0);
        chk("reset.push",  128'(push_rr),  128'd0);
        chk("reset.dpush", 128'(dpush_rr), 128'd0);
        chk("reset.busy",  128'(busy_rr),  128'd0);
        chk("reset.gid",   128'(gid_rr),   128'd0);
        chk("reset.err",   128'(err_rr),   128'd0);
        reset = 1'b0;
        cyc(1);

        // Single unicast: driver 2 sends to driver 1.
        set_pkt(2, 8'h01, 16'hABCD);
        pndng = 4'b0100;
        cyc(1);
        chk("uni.pop",  128'(pop_rr), 128'h4);
        chk("uni.gid",  128'(gid_rr), 128'd2);
        chk("uni.busy", 128'(busy_rr), 128'd1);
        pndng = '0;
        cyc(1);
        chk("uni.push",  128'(push_rr), 128'h2);
        chk("uni.slice", 128'(dpush_rr[2*W-1:W]), 128'h0100ABCD);
        cyc(1);
        chk("uni.idle",  128'(push_rr), 128'h0);
        chk("uni.nbusy", 128'(busy_rr), 128'd0);

        // Broadcast from driver 0.
        set_pkt(0, 8'hFF, 16'h1234);
        pndng = 4'b0001;
        cyc(1);
        chk("bc.pop", 128'(pop_rr), 128'h1);
        pndng = '0;
        cyc(1);
        chk("bc.push",  128'(push_rr),  128'hE);
        chk("bc.dpush", 128'(dpush_rr), {4{32'hFF001234}});
        cyc(1);
        chk("bc.end", 128'(push_rr), 128'h0);

        // Invalid destination 8'h07 from driver 1.
        set_pkt(1, 8'h07, 16'h5555);
        pndng = 4'b0010;
        cyc(1);
        pndng = '0;
        cyc(1);
        chk("inv.push", 128'(push_rr), 128'h0);
        chk("inv.err",  128'(err_rr),  128'(EXP_ERR));
        cyc(1);
        chk("inv.err_end", 128'(err_rr), 128'h0);

        // Reset while pop[3] is high.
        set_pkt(3, 8'h00, 16'h3333);
        set_pkt(1, 8'h02, 16'h1111);
        pndng = 4'b1000;
        cyc(1);
        chk("rst.pop3", 128'(pop_rr), 128'h8);
        #1 reset = 1'b1;
        #1;
        chk("rst.pop",   128'(pop_rr | pop_fp),     128'h0);
        chk("rst.push",  128'(push_rr | push_fp),   128'h0);
        chk("rst.busy",  128'(busy_rr | busy_fp),   128'h0);
        chk("rst.gid",   128'(gid_rr | gid_fp),     128'h0);
        chk("rst.dpush", 128'(dpush_rr | dpush_fp), 128'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        pndng = 4'b1010;
        cyc(1);
        chk("rst.first_rr", 128'(gid_rr), 128'd1);
        chk("rst.first_fp", 128'(gid_fp), 128'd1);
        chk("rst.nopush",   128'(push_rr), 128'h0);
        pndng = '0;
        cyc(3);

        // Round-robin fairness with all four drivers pending continuously.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_pkt(i, 8'((i + 1) % N), 16'(i));
        pndng = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            chk("rr.order_pop", 128'(pop_rr), 128'(4'b0001 << rr_exp[k]));
            chk("rr.order_gid", 128'(gid_rr), 128'(rr_exp[k]));
            cyc(2);
        end
        pndng = '0;
        cyc(3);

        // Fixed priority: drivers 1 and 3 pending; 3 is served only after 1 drops.
        pndng = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("fp.win1_pop", 128'(pop_fp), 128'h2);
            chk("fp.win1_gid", 128'(gid_fp), 128'd1);
            cyc(2);
        end
        pndng = 4'b1000;
        cyc(1);
        chk("fp.win3_pop", 128'(pop_fp), 128'h8);
        chk("fp.win3_gid", 128'(gid_fp), 128'd3);
        pndng = '0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
